truth_table_checker: RTL and testbench
======================================

// Module: truth_table_checker
// PURPOSE
// Self-checking sweep engine for the truth-table logic blocks (DDNF/DKNF style).
// Drives every input vector 0..2^N_IN-1 into two DUT implementations and compares both
// outputs against an internal golden table ROM. Counts mismatches and latches the first
// failing index. Sits upstream of the DUTs (stimulus) and downstream of them (checker).
// PARAMETERS
// N_IN       8                              input vector width; 2^N_IN table rows
// N_OUT      5                              output width per row
// SETTLE     2                              wait cycles between applying o_x and sampling; 0 legal
// TABLE_FILE "Table_8_5_testbench_table.txt" $readmemb file, one N_OUT-bit row per line, row 0 first
// PORTS
// clk           in   1        clock, rising-edge
// rst           in   1        synchronous active-high reset
// start         in   1        begin sweep; sampled only in IDLE or DONE
// o_x           out  N_IN     stimulus vector to both DUTs
// i_y_a         in   N_OUT    DUT A output (DKNF); bit order [0:N_OUT-1], matches table row
// i_y_b         in   N_OUT    DUT B output (DDNF); same ordering
// busy          out  1        high in SETTLE and CHECK
// done          out  1        high in DONE, held until start or rst
// pass          out  1        valid when done: 1 iff err_count == 0
// mismatch      out  1        one-cycle pulse in the CHECK cycle of a failing vector
// err_count     out  N_IN+1   number of failing vectors; max 2^N_IN, no saturation needed
// first_err_idx out  N_IN     o_x of first failing vector; 0 if none
// first_err_vld out  1        first_err_idx is valid
// BEHAVIOUR
// - Reset: state=IDLE; o_x=0, busy=0, done=0, pass=0, mismatch=0, err_count=0,
//   first_err_idx=0, first_err_vld=0. Reset mid-sweep aborts immediately, same values.
// - FSM states: IDLE, SETTLE, CHECK, DONE.
// - IDLE: on start -> clear err_count/first_err_*; o_x=0; wait=SETTLE; go SETTLE
//   (or CHECK if SETTLE==0).
// - SETTLE: decrement wait each cycle; when wait reaches 1 (or SETTLE==0), next state is CHECK.
//   o_x is stable for exactly SETTLE cycles before the CHECK cycle.
// - CHECK (1 cycle): row = ROM[o_x]. Fail = (i_y_a != row) || (i_y_b != row).
//   On fail: mismatch=1 this cycle; err_count+1; if !first_err_vld latch first_err_idx=o_x,
//   first_err_vld=1. Both DUTs failing on one vector counts once.
//   If o_x == {N_IN{1'b1}}: go DONE. Else o_x+1, reload wait, go SETTLE.
//   o_x never wraps past all-ones.
// - DONE: done=1, pass=(err_count==0); o_x holds last vector.
//   start -> restart exactly as from IDLE; results clear on the same edge.
// - start while busy is ignored. start and rst together: rst wins.
// - Latency: per vector SETTLE+1 cycles. done rises 2^N_IN*(SETTLE+1)+1 cycles after the
//   start edge (1 cycle for the IDLE->sweep transition).
// - ROM read is combinational (async array read).
// - Inputs i_y_* are sampled only in CHECK; X on i_y_* counts as mismatch.
// TESTING
// 1 Both DUTs equal ROM, SETTLE=2: start -> done after 769 cycles, pass=1, err_count=0,
//   first_err_vld=0, o_x=8'hFF.
// 2 DUT B bit y[2] forced wrong at x=8'h2A only: err_count=1, first_err_idx=8'h2A,
//   mismatch pulses once, pass=0.
// 3 Both DUTs wrong at x=8'h05 and A wrong at x=8'h80: err_count=2, first_err_idx=8'h05.
// 4 DUT A stuck at 5'b00000: err_count equals the number of nonzero ROM rows;
//   first_err_idx = lowest nonzero row.
// 5 rst asserted at x=8'h40 mid-sweep: next cycle IDLE, all outputs 0.
//   Restart runs a full clean sweep.
// 6 start pulsed during busy: no effect. start in DONE: counters clear, o_x=0, new sweep.
//   SETTLE=0 build: done after 257 cycles.

Source files
------------

// File: rtl/truth_table_checker.sv
// Sweep engine: drives every input vector to two truth-table implementations and
// checks both against a golden table. TABLE holds row i at bits [i*N_OUT +: N_OUT].
module truth_table_checker #(
    parameter int                          N_IN   = 8,
    parameter int                          N_OUT  = 5,
    parameter int                          SETTLE = 2,
    parameter logic [N_OUT*(2**N_IN)-1:0]  TABLE  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  o_x,
    input  logic [0:N_OUT-1] i_y_a,
    input  logic [0:N_OUT-1] i_y_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_err_idx,
    output logic             first_err_vld
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int              WW          = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [WW-1:0]   WAIT_LOAD   = WW'(SETTLE);
    localparam logic [N_IN-1:0] LAST_X      = '1;
    localparam state_t          SWEEP_ENTRY = (SETTLE == 0) ? S_CHECK : S_SETTLE;

    state_t            state, state_nxt;
    logic [WW-1:0]     wait_cnt, wait_nxt;
    logic [N_IN-1:0]   x_nxt;
    logic [N_IN:0]     err_nxt;
    logic [N_IN-1:0]   fidx_nxt;
    logic              fvld_nxt;
    logic [0:N_OUT-1]  row;
    logic              fail;

    // Asynchronous table read; case-inequality makes an X from either DUT a failure.
    assign row  = TABLE[int'(o_x) * N_OUT +: N_OUT];
    assign fail = (i_y_a !== row) || (i_y_b !== row);

    assign busy = (state == S_SETTLE) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == '0);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = state;
        wait_nxt  = wait_cnt;
        x_nxt     = o_x;
        err_nxt   = err_count;
        fidx_nxt  = first_err_idx;
        fvld_nxt  = first_err_vld;
        mismatch  = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = SWEEP_ENTRY;
                    wait_nxt  = WAIT_LOAD;
                    x_nxt     = '0;
                    err_nxt   = '0;
                    fidx_nxt  = '0;
                    fvld_nxt  = 1'b0;
                end
            end
            S_SETTLE: begin
                wait_nxt = wait_cnt - 1'b1;
                if (wait_cnt <= WW'(1)) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (fail) begin
                    mismatch = 1'b1;
                    err_nxt  = err_count + 1'b1;
                    if (!first_err_vld) begin
                        fidx_nxt = o_x;
                        fvld_nxt = 1'b1;
                    end
                end
                // The last vector ends the sweep instead of wrapping o_x back to zero.
                if (o_x == LAST_X) begin
                    state_nxt = S_DONE;
                end else begin
                    x_nxt     = o_x + 1'b1;
                    wait_nxt  = WAIT_LOAD;
                    state_nxt = SWEEP_ENTRY;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates land together.
        if (rst) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            o_x           <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_nxt;
            o_x           <= x_nxt;
            err_count     <= err_nxt;
            first_err_idx <= fidx_nxt;
            first_err_vld <= fvld_nxt;
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: model DUTs with injectable faults, a scoreboard
// of expected failing vectors, and a SETTLE=0 instance for the short-sweep timing.
module tb_truth_table_checker;

    localparam int N_IN   = 8;
    localparam int N_OUT  = 5;
    localparam int ROWS   = 2 ** N_IN;
    localparam int BUDGET = 2000;

    typedef enum logic [1:0] {CLEAN, B_BIT2_AT_2A, BOTH_05_A_80, A_STUCK0} fault_t;

    // Golden table: a few leading rows and every multiple of 5 are zero, the rest scrambled.
    function automatic logic [N_OUT-1:0] tb_row(input int x);
        int v;
        if (x < 4 || x % 5 == 0) return '0;
        v = (x * 13) ^ (x >> 3);
        return v[N_OUT-1:0];
    endfunction

    function automatic logic [N_OUT*ROWS-1:0] tb_table();
        logic [N_OUT*ROWS-1:0] t;
        t = '0;
        for (int i = 0; i < ROWS; i++) t[i*N_OUT +: N_OUT] = tb_row(i);
        return t;
    endfunction

    localparam logic [N_OUT*ROWS-1:0] GOLD = tb_table();

    logic             clk = 1'b0;
    logic             rst, start, start_z;
    logic [N_IN-1:0]  o_x, first_err_idx, o_x_z, fidx_z;
    logic [0:N_OUT-1] y_a, y_b, y_z, r;
    logic             busy, done, pass, mismatch, first_err_vld;
    logic             busy_z, done_z, pass_z, mm_z, fvld_z;
    logic [N_IN:0]    err_count, err_z;
    fault_t           mode = CLEAN;

    logic [N_IN-1:0]  exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               pulses = 0;

    always #5 clk = ~clk;

    truth_table_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(2), .TABLE(GOLD)) u_dut (
        .clk(clk), .rst(rst), .start(start), .o_x(o_x), .i_y_a(y_a), .i_y_b(y_b),
        .busy(busy), .done(done), .pass(pass), .mismatch(mismatch), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
    );

    truth_table_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(0), .TABLE(GOLD)) u_dut_z (
        .clk(clk), .rst(rst), .start(start_z), .o_x(o_x_z), .i_y_a(y_z), .i_y_b(y_z),
        .busy(busy_z), .done(done_z), .pass(pass_z), .mismatch(mm_z), .err_count(err_z),
        .first_err_idx(fidx_z), .first_err_vld(fvld_z)
    );

    // Model DUTs: correct rows, with the selected fault applied.
    always_comb begin
        r   = tb_row(int'(o_x));
        y_a = r;
        y_b = r;
        y_z = tb_row(int'(o_x_z));
        case (mode)
            B_BIT2_AT_2A: if (o_x == 8'h2A) y_b[2] = ~r[2];
            BOTH_05_A_80: begin
                if (o_x == 8'h05) begin
                    y_a = ~r;
                    y_b = ~r;
                end
                if (o_x == 8'h80) y_a = ~r;
            end
            A_STUCK0:     y_a = '0;
            default:      ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every mismatch pulse must match the next expected failing vector.
    always @(negedge clk) begin
        if (rst === 1'b0 && mismatch === 1'b1) begin
            pulses++;
            check("mismatch_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("mismatch_idx", o_x, exp_q.pop_front());
        end
    end

    task automatic expect_sweep(input fault_t m);
        exp_q.delete();
        case (m)
            B_BIT2_AT_2A: exp_q.push_back(8'h2A);
            BOTH_05_A_80: begin
                exp_q.push_back(8'h05);
                exp_q.push_back(8'h80);
            end
            A_STUCK0:     for (int x = 0; x < ROWS; x++) if (tb_row(x) != '0) exp_q.push_back(N_IN'(x));
            default:      ;
        endcase
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_o_x"}, o_x, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_pass"}, pass, 0);
        check({pfx, "_mismatch"}, mismatch, 0);
        check({pfx, "_err_count"}, err_count, 0);
        check({pfx, "_first_err_idx"}, first_err_idx, 0);
        check({pfx, "_first_err_vld"}, first_err_vld, 0);
    endtask

    // Cycles are counted from the edge that samples start through the edge that raises done.
    task automatic run_sweep(input fault_t m, input int poke_at, output int cycles);
        mode = m;
        expect_sweep(m);
        pulses = 0;
        @(negedge clk);
        start  = 1'b1;
        cycles = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = (cycles == poke_at);
            if (cycles == 1) begin
                check("sweep_busy", busy, 1);
                check("sweep_o_x_zero", o_x, 0);
                check("sweep_err_cleared", err_count, 0);
                check("sweep_fvld_cleared", first_err_vld, 0);
                check("sweep_pass_low", pass, 0);
            end
            if (done) break;
        end
        start = 1'b0;
        check("sweep_done_reached", done, 1);
        check("sweep_busy_low", busy, 0);
        check("sweep_o_x_last", o_x, 8'hFF);
        check("sweep_queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        int nz_count;
        int nz_first;

        rst     = 1'b1;
        start   = 1'b0;
        start_z = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Clean sweep, SETTLE=2.
        run_sweep(CLEAN, 0, cyc);
        check("clean_cycles", cyc, 769);
        check("clean_pass", pass, 1);
        check("clean_err_count", err_count, 0);
        check("clean_fvld", first_err_vld, 0);
        check("clean_fidx", first_err_idx, 0);

        // DUT B bit 2 wrong at 0x2A only; restarted straight from DONE.
        run_sweep(B_BIT2_AT_2A, 0, cyc);
        check("b2a_err_count", err_count, 1);
        check("b2a_fidx", first_err_idx, 8'h2A);
        check("b2a_fvld", first_err_vld, 1);
        check("b2a_pulses", pulses, 1);
        check("b2a_pass", pass, 0);

        // Both wrong at 0x05 (counted once) plus A wrong at 0x80.
        run_sweep(BOTH_05_A_80, 0, cyc);
        check("two_err_count", err_count, 2);
        check("two_fidx", first_err_idx, 8'h05);
        check("two_pulses", pulses, 2);
        check("two_pass", pass, 0);

        // DUT A stuck at zero: every nonzero golden row fails.
        nz_count = 0;
        nz_first = -1;
        for (int x = 0; x < ROWS; x++) begin
            if (tb_row(x) != '0) begin
                nz_count++;
                if (nz_first < 0) nz_first = x;
            end
        end
        run_sweep(A_STUCK0, 0, cyc);
        check("stuck_err_count", err_count, nz_count);
        check("stuck_fidx", first_err_idx, nz_first);
        check("stuck_pulses", pulses, nz_count);
        check("stuck_cycles", cyc, 769);

        // Reset mid-sweep at 0x40, with start raised alongside it.
        mode = CLEAN;
        expect_sweep(CLEAN);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < BUDGET && o_x != 8'h40; i++) @(negedge clk);
        check("reach_0x40", o_x, 8'h40);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("midreset");
        rst   = 1'b0;
        start = 1'b0;
        run_sweep(CLEAN, 0, cyc);
        check("after_reset_cycles", cyc, 769);
        check("after_reset_pass", pass, 1);

        // start pulsed while busy must not restart the sweep.
        run_sweep(CLEAN, 300, cyc);
        check("poke_cycles", cyc, 769);
        check("poke_pass", pass, 1);

        // SETTLE=0 instance.
        @(negedge clk);
        start_z = 1'b1;
        cyc     = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start_z = 1'b0;
            if (done_z) break;
        end
        check("settle0_done", done_z, 1);
        check("settle0_cycles", cyc, 257);
        check("settle0_pass", pass_z, 1);
        check("settle0_err_count", err_z, 0);
        check("settle0_o_x", o_x_z, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
